// File: rtl/alineador_coma.sv
// Receive-side comma aligner: finds K28.5 boundaries in the serial 8b/10b stream
// and delivers aligned 10-bit symbols, bit 9 being the first received bit.
module alineador_coma #(
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       serialIn,
    output logic [9:0] symbolOut,
    output logic       symbolValid,
    output logic       isComma,
    output logic       locked
);

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } state_t;

    localparam logic [3:0] LOCK_TH = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_TH = 4'(LOSS_COUNT);

    state_t     state, stateNext;
    logic [9:0] window, windowNext;
    logic [3:0] bitCnt, bitCntNext;
    logic [3:0] commaCnt, commaCntNext;
    logic [3:0] errCnt, errCntNext;
    logic [9:0] symbolNext;
    logic       validNext;
    logic       isCommaNext;
    logic       lockedNext;

    logic [9:0] newWindow;
    logic       commaHit;
    logic       boundary;
    logic [3:0] bitCntStep;

    // Comma detection looks at the window as it will be after this edge's shift.
    always_comb begin
        newWindow  = {window[8:0], serialIn};
        commaHit   = (newWindow == 10'h0FA) || (newWindow == 10'h305);
        boundary   = (bitCnt == 4'd9);
        bitCntStep = boundary ? 4'd0 : bitCnt + 4'd1;
    end

    always_comb begin
        stateNext    = state;
        windowNext   = window;
        bitCntNext   = bitCnt;
        commaCntNext = commaCnt;
        errCntNext   = errCnt;
        symbolNext   = symbolOut;
        validNext    = 1'b0;
        isCommaNext  = isComma;
        lockedNext   = locked;

        if (enb) begin
            windowNext = newWindow;
            bitCntNext = bitCntStep;

            case (state)
                HUNT: begin
                    if (commaHit) begin
                        bitCntNext   = 4'd0;
                        commaCntNext = 4'd1;
                        if (LOCK_TH == 4'd1) begin
                            stateNext   = LOCKED;
                            errCntNext  = 4'd0;
                            symbolNext  = newWindow;
                            validNext   = 1'b1;
                            isCommaNext = 1'b1;
                            lockedNext  = 1'b1;
                        end else begin
                            stateNext = CHECK;
                        end
                    end
                end

                // A comma off the tentative boundary restarts the count at the new position.
                CHECK: begin
                    if (commaHit) begin
                        if (boundary) begin
                            if (commaCnt + 4'd1 == LOCK_TH) begin
                                stateNext    = LOCKED;
                                commaCntNext = LOCK_TH;
                                errCntNext   = 4'd0;
                                symbolNext   = newWindow;
                                validNext    = 1'b1;
                                isCommaNext  = 1'b1;
                                lockedNext   = 1'b1;
                            end else begin
                                commaCntNext = commaCnt + 4'd1;
                            end
                        end else begin
                            bitCntNext   = 4'd0;
                            commaCntNext = 4'd1;
                        end
                    end
                end

                // Misaligned commas erode lock without moving the boundary.
                LOCKED: begin
                    if (boundary) begin
                        symbolNext  = newWindow;
                        validNext   = 1'b1;
                        isCommaNext = commaHit;
                        if (commaHit) begin
                            errCntNext = 4'd0;
                        end
                    end else if (commaHit) begin
                        if (errCnt + 4'd1 == LOSS_TH) begin
                            stateNext    = HUNT;
                            lockedNext   = 1'b0;
                            bitCntNext   = 4'd0;
                            commaCntNext = 4'd0;
                            errCntNext   = 4'd0;
                        end else begin
                            errCntNext = errCnt + 4'd1;
                        end
                    end
                end

                default: begin
                    stateNext  = HUNT;
                    lockedNext = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= HUNT;
            window      <= '0;
            bitCnt      <= '0;
            commaCnt    <= '0;
            errCnt      <= '0;
            symbolOut   <= '0;
            symbolValid <= 1'b0;
            isComma     <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= stateNext;
            window      <= windowNext;
            bitCnt      <= bitCntNext;
            commaCnt    <= commaCntNext;
            errCnt      <= errCntNext;
            symbolOut   <= symbolNext;
            symbolValid <= validNext;
            isComma     <= isCommaNext;
            locked      <= lockedNext;
        end
    end

endmodule

// File: tb/tb_alineador_coma.sv
// Directed bench for alineador_coma: acquisition, data, loss of lock, realignment,
// enable hold and asynchronous reset, with hand-computed expected symbols.
module tb_alineador_coma;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enb = 1'b0;
    logic       serialIn = 1'b0;
    logic [9:0] symbolOut;
    logic       symbolValid;
    logic       isComma;
    logic       locked;

    int checkCount = 0;
    int passCount = 0;

    localparam logic [9:0] COMMA_P = 10'h0FA;
    localparam logic [9:0] COMMA_N = 10'h305;
    localparam logic [9:0] DATA    = 10'h274;

    alineador_coma #(
        .LOCK_COUNT(3),
        .LOSS_COUNT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .serialIn   (serialIn),
        .symbolOut  (symbolOut),
        .symbolValid(symbolValid),
        .isComma    (isComma),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Shifts out the top nbits of word, MSB first; symbolValid must pulse only on edge validPos.
    task automatic applyStimulus(input logic [9:0] word, input int nbits, input int validPos,
                                 input logic [9:0] expSym, input logic expComma,
                                 input logic expLocked, input string tag);
        int         badValid = 0;
        logic [9:0] capSym = '0;
        logic       capComma = 1'b0;
        for (int i = 1; i <= nbits; i++) begin
            serialIn = word[10-i];
            @(posedge clk);
            #1;
            if (symbolValid !== (i == validPos)) badValid++;
            if (i == validPos) begin
                capSym   = symbolOut;
                capComma = isComma;
            end
        end
        checkOutput({tag, " valid pattern"}, 16'(badValid), 16'd0);
        if (validPos > 0) begin
            checkOutput({tag, " symbolOut"}, {6'd0, capSym}, {6'd0, expSym});
            checkOutput({tag, " isComma"}, {15'd0, capComma}, {15'd0, expComma});
        end
        checkOutput({tag, " locked"}, {15'd0, locked}, {15'd0, expLocked});
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " symbolOut"}, {6'd0, symbolOut}, 16'd0);
        checkOutput({tag, " symbolValid"}, {15'd0, symbolValid}, 16'd0);
        checkOutput({tag, " isComma"}, {15'd0, isComma}, 16'd0);
        checkOutput({tag, " locked"}, {15'd0, locked}, 16'd0);
    endtask

    initial begin
        int holdBad;
        logic [9:0] tail;

        #1 rst = 1'b0;
        #11;
        checkAllZero("reset");
        rst = 1'b1;
        enb = 1'b1;

        // Three back-to-back commas: silent for 29 edges, lock on edge 30.
        applyStimulus(COMMA_P, 10, 0, 10'h000, 1'b0, 1'b0, "acq1");
        applyStimulus(COMMA_P, 10, 0, 10'h000, 1'b0, 1'b0, "acq2");
        applyStimulus(COMMA_P, 10, 10, COMMA_P, 1'b1, 1'b1, "acq3");

        for (int k = 0; k < 3; k++) begin
            applyStimulus(DATA, 10, 10, DATA, 1'b0, 1'b1, "data");
        end

        // Enable dropped for five edges, four bits into a symbol.
        applyStimulus(DATA, 4, 0, 10'h000, 1'b0, 1'b1, "prehold");
        enb = 1'b0;
        holdBad = 0;
        for (int k = 0; k < 5; k++) begin
            serialIn = ~serialIn;
            @(posedge clk);
            #1;
            if (symbolValid !== 1'b0) holdBad++;
        end
        checkOutput("hold valid", 16'(holdBad), 16'd0);
        checkOutput("hold locked", {15'd0, locked}, 16'd1);
        enb = 1'b1;
        tail = DATA << 4;
        applyStimulus(tail, 6, 6, DATA, 1'b0, 1'b1, "posthold");
        applyStimulus(DATA, 10, 10, DATA, 1'b0, 1'b1, "posthold2");

        // Three extra bits shift the commas off the boundary by three.
        applyStimulus(10'h000, 3, 0, 10'h000, 1'b0, 1'b1, "extra");
        applyStimulus(COMMA_P, 10, 7, 10'h01F, 1'b0, 1'b1, "mis1");
        applyStimulus(COMMA_P, 10, 7, 10'h11F, 1'b0, 1'b1, "mis2");
        applyStimulus(COMMA_P, 10, 7, 10'h11F, 1'b0, 1'b1, "mis3");
        applyStimulus(COMMA_P, 10, 7, 10'h11F, 1'b0, 1'b0, "mis4");
        applyStimulus(COMMA_P, 10, 0, 10'h000, 1'b0, 1'b0, "reacq5");
        applyStimulus(COMMA_P, 10, 0, 10'h000, 1'b0, 1'b0, "reacq6");
        applyStimulus(COMMA_P, 10, 10, COMMA_P, 1'b1, 1'b1, "reacq7");
        applyStimulus(DATA, 10, 10, DATA, 1'b0, 1'b1, "newalign");

        // Asynchronous reset between edges while locked and just after a valid pulse.
        #2 rst = 1'b0;
        #1;
        checkAllZero("asyncrst");
        rst = 1'b1;
        applyStimulus(COMMA_P, 10, 0, 10'h000, 1'b0, 1'b0, "relock1");
        applyStimulus(COMMA_P, 10, 0, 10'h000, 1'b0, 1'b0, "relock2");
        applyStimulus(COMMA_P, 10, 10, COMMA_P, 1'b1, 1'b1, "relock3");

        // Reset mid-symbol, then one comma into CHECK, junk, and realignment.
        applyStimulus(DATA, 5, 0, 10'h000, 1'b0, 1'b1, "midsym");
        #2 rst = 1'b0;
        #1;
        checkOutput("midsym rst locked", {15'd0, locked}, 16'd0);
        rst = 1'b1;
        applyStimulus(COMMA_P, 10, 0, 10'h000, 1'b0, 1'b0, "chk1");
        applyStimulus(10'h000, 4, 0, 10'h000, 1'b0, 1'b0, "junk");
        applyStimulus(COMMA_P, 10, 0, 10'h000, 1'b0, 1'b0, "realign1");
        applyStimulus(COMMA_P, 10, 0, 10'h000, 1'b0, 1'b0, "realign2");
        applyStimulus(COMMA_P, 10, 10, COMMA_P, 1'b1, 1'b1, "realign3");

        // Negative-disparity comma is also recognised on the boundary.
        applyStimulus(COMMA_N, 10, 10, COMMA_N, 1'b1, 1'b1, "commaN");
        applyStimulus(DATA, 10, 10, DATA, 1'b0, 1'b1, "final");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
